// File: rtl/sr_drive_pkg.sv
// Shared types and default timing for the SR drive sequencer.
package sr_drive_pkg;

    typedef enum logic [1:0] {IDLE, SET_P, CLR_P, GUARD} state_t;

    localparam int DB_CYCLES_DEF    = 4;
    localparam int PULSE_CYCLES_DEF = 1;
    localparam int GUARD_CYCLES_DEF = 2;

    // Timer must hold the longer of the pulse and guard lengths.
    function automatic int tmr_width(input int pulse, input int guard);
        int m;
        m = (pulse > guard) ? pulse : guard;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer, counter-based debounce filter and rising-edge event for one request line.
module sync_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic rise_o
);
    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic             sync1_q, sync2_q;
    logic             filt_q, filt_d, filt_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any cycle where the synced level agrees with the filtered level restarts the count.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) filt_d = ~filt_q;
            else                                cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            filt_q     <= 1'b0;
            filt_dly_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= raw_i;
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
            cnt_q      <= cnt_d;
        end
    end

    assign rise_o = filt_q & ~filt_dly_q;

endmodule

// File: rtl/sr_drive_sequencer.sv
// Conditions raw set/clear requests and sequences them into non-overlapping s/r pulses
// with a dead-time guard, pending-request merge and optional redundant-command drop.
module sr_drive_sequencer
    import sr_drive_pkg::*;
#(
    parameter int DB_CYCLES      = DB_CYCLES_DEF,
    parameter int PULSE_CYCLES   = PULSE_CYCLES_DEF,
    parameter int GUARD_CYCLES   = GUARD_CYCLES_DEF,
    parameter int SET_PRIORITY   = 1,
    parameter int SKIP_REDUNDANT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_in,
    input  logic clr_in,
    input  logic q_fb,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
);
    localparam int TMR_W = tmr_width(PULSE_CYCLES, GUARD_CYCLES);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             pend_set_q, pend_set_d, pend_clr_q, pend_clr_d;
    logic             s_q, s_d, r_q, r_d, busy_q, busy_d, conflict_q, conflict_d;
    logic             set_ev, clr_ev;
    logic             accept, want_set, want_clr, pick_set, drop;

    sync_debounce #(.DB_CYCLES(DB_CYCLES)) u_set_db (
        .clk(clk), .rst(rst), .raw_i(set_in), .rise_o(set_ev)
    );
    sync_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr_db (
        .clk(clk), .rst(rst), .raw_i(clr_in), .rise_o(clr_ev)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            pend_set_q <= 1'b0;
            pend_clr_q <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            pend_set_q <= pend_set_d;
            pend_clr_q <= pend_clr_d;
            s_q        <= s_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        pend_set_d = pend_set_q;
        pend_clr_d = pend_clr_q;
        accept     = 1'b0;
        want_set   = 1'b0;
        want_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                accept   = 1'b1;
                want_set = set_ev;
                want_clr = clr_ev;
            end
            SET_P, CLR_P: begin
                pend_set_d = pend_set_q | set_ev;
                pend_clr_d = pend_clr_q | clr_ev;
                if (tmr_q == '0) begin
                    state_d = GUARD;
                    tmr_d   = TMR_W'(GUARD_CYCLES - 1);
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            GUARD: begin
                if (tmr_q == '0) begin
                    // An event landing on the exit cycle is served together with the pends.
                    accept     = 1'b1;
                    want_set   = pend_set_q | set_ev;
                    want_clr   = pend_clr_q | clr_ev;
                    pend_set_d = 1'b0;
                    pend_clr_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    tmr_d      = tmr_q - TMR_W'(1);
                    pend_set_d = pend_set_q | set_ev;
                    pend_clr_d = pend_clr_q | clr_ev;
                end
            end
            default: state_d = IDLE;
        endcase

        pick_set = (want_set && want_clr) ? (SET_PRIORITY != 0) : want_set;
        drop     = (SKIP_REDUNDANT != 0) && (pick_set ? q_fb : !q_fb);
        if (accept && (want_set || want_clr) && !drop) begin
            state_d = pick_set ? SET_P : CLR_P;
            tmr_d   = TMR_W'(PULSE_CYCLES - 1);
        end
    end

    always_comb begin
        s_d        = (state_d == SET_P);
        r_d        = (state_d == CLR_P);
        busy_d     = (state_d != IDLE);
        conflict_d = accept & want_set & want_clr;
    end

    assign s        = s_q;
    assign r        = r_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_drive_sequencer.sv
// Drives two sequencer variants (defaults, and clear-priority with 4-cycle pulses), each closing
// the loop through an SR flop, and checks them against a timeline model of the request rules.
module tb_sr_drive_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       set_in = 1'b0;
    logic       clr_in = 1'b0;
    logic [1:0] s, r, busy, conflict;
    logic [1:0] q = 2'b00;

    always #5 clk = ~clk;

    sr_drive_sequencer #(.DB_CYCLES(4), .PULSE_CYCLES(1), .GUARD_CYCLES(2),
                         .SET_PRIORITY(1), .SKIP_REDUNDANT(1)) dut_a (
        .clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in), .q_fb(q[0]),
        .s(s[0]), .r(r[0]), .busy(busy[0]), .conflict(conflict[0])
    );
    sr_drive_sequencer #(.DB_CYCLES(4), .PULSE_CYCLES(4), .GUARD_CYCLES(2),
                         .SET_PRIORITY(0), .SKIP_REDUNDANT(1)) dut_b (
        .clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in), .q_fb(q[1]),
        .s(s[1]), .r(r[1]), .busy(busy[1]), .conflict(conflict[1])
    );

    // Downstream SR flops closing the feedback loop.
    always @(posedge clk)
        for (int k = 0; k < 2; k++)
            if (s[k])      q[k] <= 1'b1;
            else if (r[k]) q[k] <= 1'b0;

    localparam int DB = 4, GRD = 2;
    int PUL[2] = '{1, 4};
    bit PRI[2] = '{1'b1, 1'b0};

    // Model: raw history window, filtered levels, and per-variant pulse/guard countdowns.
    bit hs[16], hc[16];
    bit fs, fc, fps, fpc;
    int pl[2], gl[2];
    bit ks[2], pnds[2], pndc[2];
    bit ms[2], mr[2], mb[2], mc[2], mq[2];

    int n_vec = 0, n_err = 0, tix = 0;
    int n_s[2], n_r[2], n_c[2], n_b[2], first_s[2], first_r[2];

    task automatic chk(input string tag, input logic got, input logic exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s tick=%0d got=%b exp=%b", tag, tix, got, exp);
        end
    endtask

    task automatic chki(input string tag, input int got, input int exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic serve(input int k, input bit a, input bit b, input bit qb);
        bit w;
        if (a || b) begin
            if (a && b) mc[k] = 1'b1;
            w = (a && b) ? PRI[k] : a;
            if (!(w ? qb : !qb)) begin
                pl[k] = PUL[k];
                ks[k] = w;
            end
        end
    endtask

    task automatic model_step(input bit rs, input bit rc, input bit rr);
        bit es, ec, a, b, mis_s, mis_c;
        bit qb[2];
        for (int k = 0; k < 2; k++) begin
            qb[k] = mq[k];
            if (ms[k])      mq[k] = 1'b1;
            else if (mr[k]) mq[k] = 1'b0;
        end
        if (rr) begin
            for (int i = 0; i < 16; i++) begin hs[i] = 0; hc[i] = 0; end
            fs = 0; fc = 0; fps = 0; fpc = 0;
            for (int k = 0; k < 2; k++) begin
                pl[k] = 0; gl[k] = 0; pnds[k] = 0; pndc[k] = 0;
                ms[k] = 0; mr[k] = 0; mb[k] = 0; mc[k] = 0;
            end
            return;
        end
        es = fs & ~fps;
        ec = fc & ~fpc;
        for (int k = 0; k < 2; k++) begin
            mc[k] = 1'b0;
            if (pl[k] > 0) begin
                pnds[k] |= es; pndc[k] |= ec;
                pl[k]--;
                if (pl[k] == 0) gl[k] = GRD;
            end else if (gl[k] > 0) begin
                a = pnds[k] | es; b = pndc[k] | ec;
                gl[k]--;
                if (gl[k] == 0) begin
                    pnds[k] = 0; pndc[k] = 0;
                    serve(k, a, b, qb[k]);
                end else begin
                    pnds[k] = a; pndc[k] = b;
                end
            end else begin
                serve(k, es, ec, qb[k]);
            end
            ms[k] = (pl[k] > 0) && ks[k];
            mr[k] = (pl[k] > 0) && !ks[k];
            mb[k] = (pl[k] > 0) || (gl[k] > 0);
        end
        // A level change is accepted once the last DB synced samples all disagree with it.
        mis_s = 1; mis_c = 1;
        for (int j = 1; j <= DB; j++) begin
            if (hs[j] == fs) mis_s = 0;
            if (hc[j] == fc) mis_c = 0;
        end
        fps = fs; fpc = fc;
        if (mis_s) fs = ~fs;
        if (mis_c) fc = ~fc;
        for (int i = 15; i > 0; i--) begin hs[i] = hs[i-1]; hc[i] = hc[i-1]; end
        hs[0] = rs; hc[0] = rc;
    endtask

    task automatic tick(input logic rs, input logic rc, input logic rr);
        set_in = rs; clr_in = rc; rst = rr;
        model_step(rs, rc, rr);
        @(posedge clk);
        @(negedge clk);
        tix++;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("s[%0d]", k), s[k], ms[k]);
            chk($sformatf("r[%0d]", k), r[k], mr[k]);
            chk($sformatf("busy[%0d]", k), busy[k], mb[k]);
            chk($sformatf("conflict[%0d]", k), conflict[k], mc[k]);
            chk($sformatf("q[%0d]", k), q[k], mq[k]);
            chk($sformatf("excl[%0d]", k), s[k] & r[k], 1'b0);
            if (s[k]) begin n_s[k]++; if (first_s[k] < 0) first_s[k] = tix; end
            if (r[k]) begin n_r[k]++; if (first_r[k] < 0) first_r[k] = tix; end
            if (conflict[k]) n_c[k]++;
            if (busy[k]) n_b[k]++;
        end
    endtask

    task automatic run(input logic rs, input logic rc, input int n);
        repeat (n) tick(rs, rc, 1'b0);
    endtask

    task automatic clr_stats();
        tix = 0;
        for (int k = 0; k < 2; k++) begin
            n_s[k] = 0; n_r[k] = 0; n_c[k] = 0; n_b[k] = 0;
            first_s[k] = -1; first_r[k] = -1;
        end
    endtask

    initial begin
        bit rs, rc, rr;
        clr_stats();
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        chk("rst_busy", busy[0], 1'b0);
        chk("rst_s", s[1], 1'b0);
        run(0, 0, 4);

        // Clean set, flops start at q=0
        clr_stats(); run(1, 0, 10); run(0, 0, 12);
        chki("t1_first_s_a", first_s[0], 7);
        chki("t1_ns_a", n_s[0], 1);
        chki("t1_busy_a", n_b[0], 3);
        chk("t1_q_a", q[0], 1'b1);
        chki("t1_first_s_b", first_s[1], 7);
        chki("t1_ns_b", n_s[1], 4);
        chki("t1_busy_b", n_b[1], 6);

        // Glitch shorter than the debounce window
        clr_stats(); run(1, 0, 3); run(0, 0, 10);
        chki("t2_ns_a", n_s[0], 0);
        chki("t2_busy_a", n_b[0], 0);
        chki("t2_busy_b", n_b[1], 0);

        // Bounce, after clearing both flops
        run(0, 1, 10); run(0, 0, 12);
        clr_stats();
        run(1, 0, 1); run(0, 0, 1); run(1, 0, 1); run(0, 0, 1); run(1, 0, 11); run(0, 0, 12);
        chki("t3_ns_a", n_s[0], 1);
        chki("t3_busy_a", n_b[0], 3);
        chki("t3_ns_b", n_s[1], 4);

        // Conflict with both flops at 0: A sets, B's clear win is redundant
        run(0, 1, 10); run(0, 0, 12);
        clr_stats(); run(1, 1, 10); run(0, 0, 12);
        chki("t4a_ns_a", n_s[0], 1);
        chki("t4a_nr_a", n_r[0], 0);
        chki("t4a_nc_a", n_c[0], 1);
        chki("t4a_nc_b", n_c[1], 1);
        chki("t4a_busy_b", n_b[1], 0);

        // Conflict with both flops at 1: B clears, A's set win is redundant
        run(1, 0, 10); run(0, 0, 12);
        clr_stats(); run(1, 1, 10); run(0, 0, 12);
        chki("t4b_ns_a", n_s[0] + n_r[0], 0);
        chki("t4b_nc_a", n_c[0], 1);
        chki("t4b_nr_b", n_r[1], 4);
        chki("t4b_ns_b", n_s[1], 0);
        chki("t4b_nc_b", n_c[1], 1);

        // Clear event arriving during the set pulse is pended and served after the guard
        run(0, 1, 10); run(0, 0, 12);
        clr_stats(); run(1, 0, 1); run(1, 1, 11); run(0, 0, 14);
        chki("t5_ns_a", n_s[0], 1);
        chki("t5_nr_a", n_r[0], 1);
        chki("t5_gap_a", first_r[0] - first_s[0], 3);
        chki("t5_nc_a", n_c[0], 0);
        chki("t5_nr_b", n_r[1], 4);
        chki("t5_gap_b", first_r[1] - first_s[1], 6);

        // Redundant set with q=1
        run(1, 0, 10); run(0, 0, 12);
        clr_stats(); run(1, 0, 10); run(0, 0, 12);
        chki("t6_ns_a", n_s[0], 0);
        chki("t6_busy_b", n_b[1], 0);

        // Reset mid-pulse on the 4-cycle variant with a clear pended
        run(0, 1, 10); run(0, 0, 12);
        clr_stats(); run(1, 0, 1); run(1, 1, 7);
        chki("t6_mid_ns_b", n_s[1], 2);
        tick(1'b0, 1'b0, 1'b1);
        chk("t6_rst_s_b", s[1], 1'b0);
        chk("t6_rst_busy_b", busy[1], 1'b0);
        clr_stats(); run(0, 0, 15);
        chki("t6_nr_a", n_r[0], 0);
        chki("t6_nr_b", n_r[1], 0);

        // Random bouncing requests with occasional resets
        rs = 0; rc = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(7) == 0) rs = ~rs;
            if ($urandom_range(7) == 0) rc = ~rc;
            rr = ($urandom_range(299) == 0);
            tick(rs, rc, rr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
